// File: rtl/sel_arb_pkg.sv
// Shared types and defaults for the two-requester mux-select arbiter.
// No logic; state encoding and the default per-requester hold limit only.
package sel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam int HOLD_MAX_DEFAULT = 4;

endpackage

// File: rtl/hold_ctr.sv
// Saturating hold counter: load forces 1, inc counts up and sticks at MAX.
// Latency: count updates on the edge after load/inc; no backpressure.
module hold_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LIMIT = W'(MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(1);
    end else if (inc && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sel_arbiter.sv
// Two-requester arbiter driving a shared mux select with bounded hold time.
// Latency: request sampled at edge N is granted after edge N; all outputs registered.
// Backpressure: level-sensitive requests, nothing queued while not granted.
module sel_arbiter
  import sel_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b,
  output logic busy
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(HOLD_MAX);

  state_t        state;
  state_t        state_nxt;
  logic          last_a;    // 1 when A was the most recent grant entry
  logic          ctr_load;
  logic          ctr_inc;
  logic [CW-1:0] count;
  logic          at_limit;

  assign at_limit = (count == HOLD_LIMIT);

  hold_ctr #(
    .MAX (HOLD_MAX),
    .W   (CW)
  ) u_hold_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .inc   (ctr_inc),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    ctr_load  = 1'b0;
    ctr_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || !last_a)) begin
          state_nxt = GRANT_A;
          ctr_load  = 1'b1;
        end else if (req_b) begin
          state_nxt = GRANT_B;
          ctr_load  = 1'b1;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          state_nxt = req_b ? GRANT_B : IDLE;
          ctr_load  = req_b;
        end else if (!at_limit) begin
          ctr_inc = 1'b1;
        end else begin
          // Hold expired: hand over if B waits, otherwise restart A's window.
          ctr_load = 1'b1;
          if (req_b) state_nxt = GRANT_B;
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_nxt = req_a ? GRANT_A : IDLE;
          ctr_load  = req_a;
        end else if (!at_limit) begin
          ctr_inc = 1'b1;
        end else begin
          ctr_load = 1'b1;
          if (req_a) state_nxt = GRANT_A;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 1'b0;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      busy   <= 1'b0;
      last_a <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_a <= (state_nxt == GRANT_A);
      gnt_b <= (state_nxt == GRANT_B);
      busy  <= (state_nxt != IDLE);
      // Select only moves on a grant; IDLE keeps the mux where it was.
      if (state_nxt == GRANT_A) sel <= 1'b1;
      else if (state_nxt == GRANT_B) sel <= 1'b0;
      if (ctr_load) last_a <= (state_nxt == GRANT_A);
    end
  end

endmodule

// File: doc/sel_arbiter.md
SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_MAX, default 4, giving the maximum consecutive grant cycles per requester; legal range 1..255.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The module SHALL have port req_a, input, 1, requester A wants the mux path (mux sel=1 routes a).
REQ-005 The module SHALL have port req_b, input, 1, requester B wants the mux path (mux sel=0 routes b).
REQ-006 The module SHALL have port sel, output, 1, drives the downstream mux sel input shared by all mux instances.
REQ-007 The module SHALL have port gnt_a, output, 1, A currently owns the path.
REQ-008 The module SHALL have port gnt_b, output, 1, B currently owns the path.
REQ-009 The module SHALL have port busy, output, 1, equals gnt_a | gnt_b.

Function
REQ-010 The module SHALL implement states IDLE, GRANT_A, GRANT_B; all outputs SHALL be registered and derived from state.
REQ-011 gnt_a and gnt_b SHALL be one-hot-or-zero in every cycle.
REQ-012 sel SHALL be 1 in GRANT_A, 0 in GRANT_B, and hold its previous value in IDLE (no glitching of the shared mux select).
REQ-013 Latency: a request sampled at edge N SHALL produce its grant at the output after edge N (visible in cycle N+1); no combinational req-to-gnt path.
REQ-014 IDLE with one request SHALL move to that requester's grant state.
REQ-015 IDLE with both requests SHALL grant the requester not served last (last-served pointer, 1 bit).
REQ-016 A hold counter SHALL load 1 on entry to a grant state and increment each cycle the grant persists; width ceil(log2(HOLD_MAX+1)) bits, never wraps.
REQ-017 In GRANT_x, if req_x is deasserted: go to the other grant state if the other requests, else IDLE.
REQ-018 In GRANT_x, if req_x is held and counter < HOLD_MAX: stay.
REQ-019 In GRANT_x, if counter == HOLD_MAX and the other requests: switch directly to the other grant state (no IDLE bubble); if the other does not request: re-enter GRANT_x with counter reloaded to 1.
REQ-020 The last-served pointer SHALL update on every entry into a grant state.
REQ-021 HOLD_MAX = 1 SHALL yield strict alternation under continuous dual requests.
REQ-022 Requests are level-sensitive; no request is stored while not granted.

Reset
REQ-023 While rst=1 at an edge: state=IDLE, sel=0, gnt_a=0, gnt_b=0, busy=0, counter=0, last-served=B (so A wins the first tie).
REQ-024 Reset asserted mid-grant SHALL drop the grant at the next edge regardless of requests; first grant after reset release follows REQ-013.

Structure
REQ-025 A shared package sel_arb_pkg SHALL hold the state enum type and the default HOLD_MAX constant.
REQ-026 The hold counter SHALL be a sub-module hold_ctr (inputs clk, rst, load, inc; output count; parameter MAX); all other logic is in sel_arbiter.

Verification
REQ-027 Reset: rst=1 two cycles with req_a=req_b=1 -> sel=0, gnt_a=gnt_b=0 throughout; after release, gnt_a=1, sel=1 one cycle later.
REQ-028 Single requester: req_b=1 for 10 cycles, HOLD_MAX=4 -> gnt_b=1 continuous for 10 cycles, sel=0, counter reloads every 4 cycles.
REQ-029 Contention: req_a=req_b=1 continuously, HOLD_MAX=4 -> gnt_a 4 cycles, gnt_b 4 cycles, repeating, no IDLE cycle between, sel toggles exactly at handover.
REQ-030 Early release: A granted, drop req_a on grant cycle 2 with req_b=1 -> gnt_b=1 next cycle; with req_b=0 -> IDLE, sel stays 1.
REQ-031 HOLD_MAX=1 with both requesting 6 cycles -> grants A,B,A,B,A,B.
REQ-032 Mid-operation reset: assert rst during GRANT_B cycle 3 -> all grants 0 and sel=0 next cycle; counter restarts at 1 on next grant.
